baccarat_datapath: RTL and testbench
====================================

// Module: baccarat_datapath
// PURPOSE
//  Card/score datapath of the baccarat engine. Deals a card value, latches it into one of six
//  card registers (player 1-3, dealer 1-3) under FSM load strobes, and computes both hand scores.
//  It also drives six active-low 7-segment digits. The FSM sits above it and uses pcard3_out and
//  the scores to decide draws.
// PARAMETERS
//  none
// PORTS
//  slow_clock   in   1  sole clock; all state updates on posedge
//  reset        in   1  synchronous, active-high reset
//  load_pcard1  in   1  latch new_card into player card 1 (pcard1_out)
//  load_pcard2  in   1  latch new_card into player card 2 (pcard2_out)
//  load_pcard3  in   1  latch new_card into player card 3
//  load_dcard1  in   1  latch new_card into dealer card 1 (dcard1_out)
//  load_dcard2  in   1  latch new_card into dealer card 2 (dcard2_out)
//  load_dcard3  in   1  latch new_card into dealer card 3 (dcard3_out)
//  pcard3_out   out  4  player card 3 register value
//  pscore_out   out  4  player score 0..9
//  dscore_out   out  4  dealer score 0..9
//  HEX5..HEX0   out  7  each digit; bit6=g..bit0=a, 0=segment lit
// BEHAVIOUR
//  - Card code: 0=no card, 1=A, 2-9, 10, 11=J, 12=Q, 13=K; 14/15 never produced.
//  - Dealer source: internal 4-bit counter new_card.
//    - Reset value is 1.
//    - Each non-reset posedge it steps 1->2->...->13->1, whether or not a load is active.
//  - Six 4-bit card regs; on posedge: reset -> 0; else load_x=1 -> reg<=new_card (pre-step
//    value); else hold.
//    - Simultaneous loads all capture the same new_card.
//    - Reset overrides loads. Reset mid-hand clears every card and therefore both scores.
//    - Load latency 1 cycle; the value is visible right after the posedge.
//  - Card value for scoring: codes 1-9 map to themselves; 0 and 10-15 map to 0.
//  - pscore_out = (v(pcard1)+v(pcard2)+v(pcard3)) mod 10; dscore_out likewise for dealer cards.
//    - Purely combinational. Sum fits in 5 bits (max 27); mod by compare/subtract.
//  - Outputs are 0 after reset: all cards, pcard3_out, pscore_out, dscore_out.
//  - Display map: HEX0=pcard1 HEX1=pcard2 HEX2=pcard3 HEX3=dcard1 HEX4=dcard2 HEX5=dcard3.
//  - Combinational 7-seg encode (6..0):
//    - 0/14/15 -> blank 1111111
//    - 1 A -> 0001000; 2 -> 0100100; 3 -> 0110000; 4 -> 0011001
//    - 5 -> 0010010; 6 -> 0000010; 7 -> 1111000; 8 -> 0000000
//    - 9 -> 0010000; 10 ("0") -> 1000000; 11 J -> 1100001; 12 q -> 0011000; 13 K -> 0001001
//  - Pattern 0001110 ("F") is never driven.
//  - Internal nets new_card, pcard1_out, pcard2_out, dcard1_out..dcard3_out keep these names;
//    the bench probes them.
// CONFIGURATION
//  - DATAPATH_LFSR_EN undefined: sequential counter source as above.
//  - DATAPATH_LFSR_EN defined: card source is a 5-bit Fibonacci LFSR.
//    - Taps x^5+x^3+1; reset seed 5'b00001; steps every non-reset posedge.
//    - new_card = (lfsr mod 13)+1, so always 1..13.
//  - Everything else is identical in both builds.
// TESTING
//  - Reset held 1 cycle -> all six cards 0, pscore=dscore=0, all HEX=1111111, new_card=1.
//  - Reset released, load_pcard1 on first posedge -> pcard1_out=1, HEX0=0001000.
//    - Two further idle posedges -> pcard1_out still 1.
//  - After reset: idle 6 cycles, then load_pcard2 -> pcard2=7; next cycle load_pcard3 -> pcard3=8.
//    - With pcard1=1: pscore_out=(1+7+8)mod10=6.
//  - Dealer cards 10, 11, 13 loaded (at counter values 10/11/13) -> dscore_out=0.
//    - HEX3/4/5 = 1000000 / 1100001 / 0001001.
//  - load_pcard1 and load_dcard1 in the same cycle with new_card=9 -> both regs 9.
//    - Then counter 13 -> next posedge new_card=1 (wrap).
//  - Reset asserted together with load_dcard2 mid-hand -> all cards 0 (reset wins), scores 0.

Source files
------------

// File: rtl/baccarat_datapath.sv
// Baccarat card/score datapath: card source, six card registers, hand scores and 7-seg digits.
// Build option DATAPATH_LFSR_EN swaps the sequential card counter for a 5-bit LFSR source.
module baccarat_datapath (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard3_out,
    output logic [3:0] pscore_out,
    output logic [3:0] dscore_out,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    logic [3:0] new_card;
    logic [3:0] pcard1_out, pcard2_out;
    logic [3:0] dcard1_out, dcard2_out, dcard3_out;

`ifdef DATAPATH_LFSR_EN
    logic [4:0] lfsr_q;
    logic [4:0] lfsr_mod;

    always_ff @(posedge slow_clock) begin
        if (reset) lfsr_q <= 5'b00001;
        else       lfsr_q <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    end

    // lfsr is at most 31, so two conditional subtracts give mod 13
    always_comb begin
        lfsr_mod = lfsr_q;
        if (lfsr_q >= 5'd26)      lfsr_mod = lfsr_q - 5'd26;
        else if (lfsr_q >= 5'd13) lfsr_mod = lfsr_q - 5'd13;
        new_card = lfsr_mod[3:0] + 4'd1;
    end
`else
    always_ff @(posedge slow_clock) begin
        if (reset)                  new_card <= 4'd1;
        else if (new_card == 4'd13) new_card <= 4'd1;
        else                        new_card <= new_card + 4'd1;
    end
`endif

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            pcard1_out <= '0;
            pcard2_out <= '0;
            pcard3_out <= '0;
            dcard1_out <= '0;
            dcard2_out <= '0;
            dcard3_out <= '0;
        end else begin
            if (load_pcard1) pcard1_out <= new_card;
            if (load_pcard2) pcard2_out <= new_card;
            if (load_pcard3) pcard3_out <= new_card;
            if (load_dcard1) dcard1_out <= new_card;
            if (load_dcard2) dcard2_out <= new_card;
            if (load_dcard3) dcard3_out <= new_card;
        end
    end

    // Face cards and tens count zero
    function automatic logic [4:0] card_val(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
    endfunction

    function automatic logic [3:0] hand_score(input logic [3:0] c1, input logic [3:0] c2,
                                              input logic [3:0] c3);
        logic [4:0] s;
        s = card_val(c1) + card_val(c2) + card_val(c3);
        if (s >= 5'd20)      s = s - 5'd20;
        else if (s >= 5'd10) s = s - 5'd10;
        return s[3:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] c);
        case (c)
            4'd1:    return 7'b0001000;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b1000000;
            4'd11:   return 7'b1100001;
            4'd12:   return 7'b0011000;
            4'd13:   return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    assign pscore_out = hand_score(pcard1_out, pcard2_out, pcard3_out);
    assign dscore_out = hand_score(dcard1_out, dcard2_out, dcard3_out);

    assign HEX0 = seg7(pcard1_out);
    assign HEX1 = seg7(pcard2_out);
    assign HEX2 = seg7(pcard3_out);
    assign HEX3 = seg7(dcard1_out);
    assign HEX4 = seg7(dcard2_out);
    assign HEX5 = seg7(dcard3_out);

endmodule

// File: tb/tb_baccarat_datapath.sv
// Randomized bench for baccarat_datapath (counter build) against a card-deal reference model.
module tb_baccarat_datapath;

    logic       slow_clock = 1'b0;
    logic       reset = 1'b0;
    logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
    logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
    logic [3:0] pcard3_out, pscore_out, dscore_out;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    int checks = 0;
    int errors = 0;

    // model: next card to deal, and the six cards (p1,p2,p3,d1,d2,d3)
    int m_next;
    int m_card [6];
    logic [6:0] segtab [16];

    baccarat_datapath dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .load_pcard1(load_pcard1),
        .load_pcard2(load_pcard2),
        .load_pcard3(load_pcard3),
        .load_dcard1(load_dcard1),
        .load_dcard2(load_dcard2),
        .load_dcard3(load_dcard3),
        .pcard3_out (pcard3_out),
        .pscore_out (pscore_out),
        .dscore_out (dscore_out),
        .HEX5       (HEX5),
        .HEX4       (HEX4),
        .HEX3       (HEX3),
        .HEX2       (HEX2),
        .HEX1       (HEX1),
        .HEX0       (HEX0)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int score(input int a, input int b, input int c);
        int s;
        s = 0;
        if (a >= 1 && a <= 9) s += a;
        if (b >= 1 && b <= 9) s += b;
        if (c >= 1 && c <= 9) s += c;
        return s % 10;
    endfunction

    task automatic check_all();
        chk("new_card", int'(dut.new_card), m_next);
        chk("pcard1", int'(dut.pcard1_out), m_card[0]);
        chk("pcard2", int'(dut.pcard2_out), m_card[1]);
        chk("pcard3", int'(pcard3_out), m_card[2]);
        chk("dcard1", int'(dut.dcard1_out), m_card[3]);
        chk("dcard2", int'(dut.dcard2_out), m_card[4]);
        chk("dcard3", int'(dut.dcard3_out), m_card[5]);
        chk("pscore", int'(pscore_out), score(m_card[0], m_card[1], m_card[2]));
        chk("dscore", int'(dscore_out), score(m_card[3], m_card[4], m_card[5]));
        chk("HEX0", int'(HEX0), int'(segtab[m_card[0]]));
        chk("HEX1", int'(HEX1), int'(segtab[m_card[1]]));
        chk("HEX2", int'(HEX2), int'(segtab[m_card[2]]));
        chk("HEX3", int'(HEX3), int'(segtab[m_card[3]]));
        chk("HEX4", int'(HEX4), int'(segtab[m_card[4]]));
        chk("HEX5", int'(HEX5), int'(segtab[m_card[5]]));
    endtask

    // One clock: model sees the same inputs the DUT samples, then compare at negedge.
    task automatic tick();
        logic [5:0] ld;
        @(posedge slow_clock);
        ld = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
        if (reset) begin
            foreach (m_card[i]) m_card[i] = 0;
            m_next = 1;
        end else begin
            for (int i = 0; i < 6; i++) if (ld[i]) m_card[i] = m_next;
            m_next = (m_next % 13) + 1;
        end
        @(negedge slow_clock);
        check_all();
    endtask

    task automatic set_loads(input logic [5:0] ld);
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
    endtask

    initial begin
        segtab[0]  = 7'b1111111; segtab[1]  = 7'b0001000; segtab[2]  = 7'b0100100;
        segtab[3]  = 7'b0110000; segtab[4]  = 7'b0011001; segtab[5]  = 7'b0010010;
        segtab[6]  = 7'b0000010; segtab[7]  = 7'b1111000; segtab[8]  = 7'b0000000;
        segtab[9]  = 7'b0010000; segtab[10] = 7'b1000000; segtab[11] = 7'b1100001;
        segtab[12] = 7'b0011000; segtab[13] = 7'b0001001; segtab[14] = 7'b1111111;
        segtab[15] = 7'b1111111;
        m_next = 1;
        foreach (m_card[i]) m_card[i] = 0;

        // reset state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_hex0", int'(HEX0), 7'b1111111);
        chk("rst_pscore", int'(pscore_out), 0);

        // first card after reset is an ace, and it holds
        set_loads(6'b000001); tick();
        chk("p1_ace", int'(dut.pcard1_out), 1);
        chk("p1_ace_hex", int'(HEX0), 7'b0001000);
        set_loads(6'b0); tick(); tick();
        chk("p1_hold", int'(dut.pcard1_out), 1);

        // idle until counter reaches 7, then 7 and 8 into player cards 2/3
        repeat (3) tick();
        set_loads(6'b000010); tick();
        set_loads(6'b000100); tick();
        chk("p2_seven", int'(dut.pcard2_out), 7);
        chk("p3_eight", int'(pcard3_out), 8);
        chk("pscore_6", int'(pscore_out), 6);

        // dealer 10, J, K: counter is 9 now
        set_loads(6'b0); tick();
        set_loads(6'b001000); tick();
        set_loads(6'b010000); tick();
        set_loads(6'b0); tick();
        set_loads(6'b100000); tick();
        chk("dscore_0", int'(dscore_out), 0);
        chk("hex3_10", int'(HEX3), 7'b1000000);
        chk("hex4_J", int'(HEX4), 7'b1100001);
        chk("hex5_K", int'(HEX5), 7'b0001001);

        // counter now 1; advance to 9, load p1 and d1 together
        set_loads(6'b0); repeat (8) tick();
        set_loads(6'b001001); tick();
        chk("sim_p1", int'(dut.pcard1_out), 9);
        chk("sim_d1", int'(dut.dcard1_out), 9);
        set_loads(6'b0); repeat (3) tick();
        chk("cnt_13", int'(dut.new_card), 13);
        tick();
        chk("cnt_wrap", int'(dut.new_card), 1);

        // reset beats a simultaneous load
        reset = 1'b1; set_loads(6'b010000); tick();
        reset = 1'b0; set_loads(6'b0);
        chk("rst_d2", int'(dut.dcard2_out), 0);
        chk("rst_dscore", int'(dscore_out), 0);
        chk("rst_pcard3", int'(pcard3_out), 0);

        // random hands with occasional reset
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 29) == 0);
            set_loads(($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
